// File: rtl/cam_sense_pkg.sv
`default_nettype none
// ============================================================================
// cam_sense_pkg : shared types, defaults and helpers for CAM match-line sensing
// Revision      : 1.0
// ============================================================================
package cam_sense_pkg;

  localparam int C_ROWS_DEF        = 16;
  localparam int C_SIG_W_DEF       = 8;
  localparam int C_EVAL_CYCLES_DEF = 2;
  localparam int C_MHIT_MAX_ROWS   = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMP_A = 3'd1,
    EVAL   = 3'd2,
    SAMP_B = 3'd3,
    HOLD   = 3'd4
  } cam_ml_state_e;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic is_multi_hit(input logic [C_MHIT_MAX_ROWS-1:0] v);
    return (v & (v - C_MHIT_MAX_ROWS'(1))) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_ml_sense_seq_if.sv
`default_nettype none
// ============================================================================
// cam_ml_sense_seq_if : search request / result handshake bundle
// Optional macro      : CAM_ML_ROW_MASK_EN adds row_mask
// Revision            : 1.0
// ============================================================================
interface cam_ml_sense_seq_if #(
  parameter int ROWS  = 16,
  parameter int SIG_W = 8
) ();
  localparam int IDX_W = $clog2(ROWS);

  logic                    start;
  logic                    abort;
  logic [SIG_W-1:0]        sa_ref;
  logic [ROWS*SIG_W-1:0]   sa_signal;
`ifdef CAM_ML_ROW_MASK_EN
  logic [ROWS-1:0]         row_mask;
`endif
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [ROWS-1:0]         match_vec;
  logic [ROWS-1:0]         pc_fault_vec;
  logic                    hit;
  logic                    multi_hit;
  logic [IDX_W-1:0]        hit_idx;

  modport master (
`ifdef CAM_ML_ROW_MASK_EN
    output row_mask,
`endif
    output start, abort, sa_ref, sa_signal, out_ready,
    input  busy, out_valid, match_vec, pc_fault_vec, hit, multi_hit, hit_idx
  );

  modport slave (
`ifdef CAM_ML_ROW_MASK_EN
    input  row_mask,
`endif
    input  start, abort, sa_ref, sa_signal, out_ready,
    output busy, out_valid, match_vec, pc_fault_vec, hit, multi_hit, hit_idx
  );
endinterface
`default_nettype wire

// File: rtl/cam_prio_enc.sv
`default_nettype none
// ============================================================================
// cam_prio_enc : combinational lowest-index priority encoder with hit flag
// Revision     : 1.0
// ============================================================================
module cam_prio_enc #(
  parameter int ROWS  = 16,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  wire logic [ROWS-1:0]  i_req,
  output logic                  o_hit,
  output logic [IDX_W-1:0]      o_idx
);

  // Scanning downward lets the lowest set row overwrite any higher one.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cam_ml_sense_seq.sv
`default_nettype none
// ============================================================================
// cam_ml_sense_seq : dual-sample CAM match-line sense sequencer with result regs
// Optional macro   : CAM_ML_ROW_MASK_EN (per-search row mask)
// Revision         : 1.0
// ============================================================================
module cam_ml_sense_seq
  import cam_sense_pkg::*;
#(
  parameter int ROWS        = C_ROWS_DEF,
  parameter int SIG_W       = C_SIG_W_DEF,
  parameter int EVAL_CYCLES = C_EVAL_CYCLES_DEF
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  cam_ml_sense_seq_if.slave  bus
);
  localparam int IDX_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(EVAL_CYCLES + 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_SAMP_A = SAMP_A;
  localparam logic [2:0] ST_EVAL   = EVAL;
  localparam logic [2:0] ST_SAMP_B = SAMP_B;
  localparam logic [2:0] ST_HOLD   = HOLD;

  logic [2:0]        state_q, state_d;
  logic [SIG_W-1:0]  ref_q, ref_d;
  logic [ROWS-1:0]   a_q, a_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [ROWS-1:0]   match_q, match_d;
  logic [ROWS-1:0]   pcf_q, pcf_d;
  logic              hit_q, hit_d;
  logic              multi_q, multi_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
`ifdef CAM_ML_ROW_MASK_EN
  logic [ROWS-1:0]   mask_q, mask_d;
`endif

  logic [ROWS-1:0]            w_sa_out;
  logic [ROWS-1:0]            w_active;
  logic [ROWS-1:0]            w_match_new;
  logic [ROWS-1:0]            w_pcf_new;
  logic [C_MHIT_MAX_ROWS-1:0] w_mh_ext;
  logic                       w_enc_hit;
  logic [IDX_W-1:0]           w_enc_idx;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_cmp
    assign w_sa_out[gi] = bus.sa_signal[gi*SIG_W +: SIG_W] > ref_q;
  end

`ifdef CAM_ML_ROW_MASK_EN
  assign w_active = ~mask_q;
`else
  assign w_active = '1;
`endif

  // Late sample is combined directly with the early one on the SAMP_B edge.
  assign w_match_new = a_q & w_sa_out & w_active;
  assign w_pcf_new   = ~a_q & w_active;

  always_comb begin
    w_mh_ext = '0;
    w_mh_ext[ROWS-1:0] = w_match_new;
  end

  cam_prio_enc #(.ROWS(ROWS), .IDX_W(IDX_W)) u_prio_enc (
    .i_req (w_match_new),
    .o_hit (w_enc_hit),
    .o_idx (w_enc_idx)
  );

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    a_d         = a_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    match_d     = match_q;
    pcf_d       = pcf_q;
    hit_d       = hit_q;
    multi_d     = multi_q;
    idx_d       = idx_q;
`ifdef CAM_ML_ROW_MASK_EN
    mask_d      = mask_q;
`endif
    if (bus.abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      match_d     = '0;
      pcf_d       = '0;
      hit_d       = 1'b0;
      multi_d     = 1'b0;
      idx_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            ref_d   = bus.sa_ref;
`ifdef CAM_ML_ROW_MASK_EN
            mask_d  = bus.row_mask;
`endif
            state_d = ST_SAMP_A;
          end
        end
        ST_SAMP_A: begin
          a_d     = w_sa_out;
          cnt_d   = CNT_W'(EVAL_CYCLES - 1);
          state_d = ST_EVAL;
        end
        ST_EVAL: begin
          if (cnt_q == '0) state_d = ST_SAMP_B;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_SAMP_B: begin
          match_d     = w_match_new;
          pcf_d       = w_pcf_new;
          hit_d       = w_enc_hit;
          multi_d     = is_multi_hit(w_mh_ext);
          idx_d       = w_enc_idx;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            if (bus.start) begin
              ref_d   = bus.sa_ref;
`ifdef CAM_ML_ROW_MASK_EN
              mask_d  = bus.row_mask;
`endif
              state_d = ST_SAMP_A;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ref_q       <= '0;
      a_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      match_q     <= '0;
      pcf_q       <= '0;
      hit_q       <= 1'b0;
      multi_q     <= 1'b0;
      idx_q       <= '0;
`ifdef CAM_ML_ROW_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      a_q         <= a_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      match_q     <= match_d;
      pcf_q       <= pcf_d;
      hit_q       <= hit_d;
      multi_q     <= multi_d;
      idx_q       <= idx_d;
`ifdef CAM_ML_ROW_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.match_vec    = match_q;
  assign bus.pc_fault_vec = pcf_q;
  assign bus.hit          = hit_q;
  assign bus.multi_hit    = multi_q;
  assign bus.hit_idx      = idx_q;

endmodule
`default_nettype wire

// File: doc/cam_ml_sense_seq.md
Name: cam_ml_sense_seq

Overview:
- Parametrised successor to the single-line CAM match-line sense/output register.
- Senses ROWS match lines against a shared reference.
- Samples each line twice per search: early, after precharge; late, after evaluate.
- Produces a registered match vector, precharge-fault vector, hit/multi-hit flags and a priority-encoded hit index.
- Sits between the CAM array's digitised match-line outputs and the HTM/reflex-memory lookup logic, with a valid/ready output handshake.

Parameters:
- ROWS, 16, number of match lines (>=2)
- SIG_W, 8, width of each digitised match-line voltage and of the reference
- EVAL_CYCLES, 2, cycles between early and late sample (>=1)
- IDX_W, $clog2(ROWS), derived; not overridden

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a search; accepted in IDLE, or in HOLD when out_ready=1
- abort  in  1  synchronous abort; overrides everything except rst_n
- sa_ref  in  SIG_W  reference voltage code; captured on start acceptance
- sa_signal  in  ROWS*SIG_W  row i at bits [i*SIG_W +: SIG_W]; unsigned
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer accepts result
- match_vec  out  ROWS  bit i = row i matched
- pc_fault_vec  out  ROWS  bit i = row i failed precharge
- hit  out  1  |match_vec
- multi_hit  out  1  two or more bits of match_vec set
- hit_idx  out  IDX_W  lowest set index of match_vec; 0 when hit=0

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; ref_q, a_q, b_q and counter cleared.
- Comparator per row: sa_out[i] = (sa_signal[i] > ref_q), unsigned, strict. Equality gives 0.
- FSM states: IDLE, SAMP_A, EVAL, SAMP_B, HOLD.
  - IDLE: on start, ref_q <= sa_ref, go to SAMP_A.
  - SAMP_A: a_q <= sa_out; cnt <= EVAL_CYCLES-1; go to EVAL.
  - EVAL: when cnt==0 go to SAMP_B, else decrement cnt.
  - SAMP_B: b_q <= sa_out; register results; out_valid <= 1; go to HOLD.
    - match_vec = a_q & sa_out
    - pc_fault_vec = ~a_q
    - hit, multi_hit and hit_idx are derived from the new match_vec in the same edge.
  - HOLD: all outputs stable while out_ready=0.
    - out_ready=1 and start=0: out_valid <= 0, go to IDLE.
    - out_ready=1 and start=1: out_valid <= 0, ref_q <= sa_ref, go directly to SAMP_A (back-to-back search).
- start is ignored in SAMP_A, EVAL and SAMP_B, and in HOLD without out_ready; it is not queued.
- Latency: start accepted at edge 0 gives out_valid high after edge 2+EVAL_CYCLES (4 cycles at default).
- abort=1 in any state: next edge goes to IDLE with out_valid=0; result vectors and flags cleared. abort with start in the same cycle: abort wins.
- Result registers change only on the SAMP_B edge, an abort, or reset.
- All-zero match_vec: hit=0, multi_hit=0, hit_idx=0.
- ROWS not a power of two: hit_idx never exceeds ROWS-1.

Optional Feature:
- Macro: CAM_ML_ROW_MASK_EN.
- Defined:
  - adds input row_mask [ROWS], captured with sa_ref on start acceptance;
  - masked rows are forced to 0 in match_vec and pc_fault_vec before hit, multi_hit and hit_idx are computed.
- Undefined: port absent; all rows are active.

Decomposition:
- Shared package cam_sense_pkg:
  - state enum cam_ml_state_e {IDLE, SAMP_A, EVAL, SAMP_B, HOLD};
  - default parameter constants;
  - function for the multi-hit test.
- One sub-module, cam_prio_enc #(ROWS, IDX_W):
  - combinational lowest-index priority encoder with hit output;
  - reused by later CAM lookup blocks.

Test Plan (ROWS=16, SIG_W=8, EVAL_CYCLES=2):
1. Reset: assert rst_n=0 mid-EVAL → all outputs 0 immediately. Release → IDLE, busy=0.
2. Dual hit, sa_ref=0x80, all rows 0xF0 during SAMP_A; during SAMP_B row5=0xC0, row9=0xA0, others 0x20.
   - Required: out_valid 4 cycles after start.
   - Required: match_vec=0x0220, hit=1, multi_hit=1, hit_idx=5, pc_fault_vec=0.
3. No hit and equality, sa_ref=0x80, early all 0xF0, late all 0x80.
   - Required: match_vec=0, hit=0, hit_idx=0 (equality is not a match).
4. Precharge fault: row3 early 0x40, late 0xF0, others as in scenario 2.
   - Required: pc_fault_vec=0x0008, match_vec bit3=0.
5. Backpressure, then back-to-back:
   - hold out_ready=0 for 10 cycles with start pulsing → outputs stable, busy=1, no new search;
   - then out_ready=1 with start=1 → next state SAMP_A, new result 4 cycles later.
6. Abort and mask:
   - abort during EVAL → IDLE next cycle, out_valid never rises.
   - With CAM_ML_ROW_MASK_EN, row_mask=0x0020, scenario 2 stimulus → match_vec=0x0200, hit_idx=9, multi_hit=0.
